// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, 8N1 framing constants
// and the bit-period helper used to size the receiver counters.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // System clocks per UART bit (integer division, truncates).
  function automatic int unsigned clks_per_bit(input int unsigned freq,
                                               input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with a two-flop input synchroniser.
//   clk, rst   : system clock, synchronous active-high reset
//   rx         : asynchronous UART line, idle high
//   rx_s       : synchronised line level (for other logic on the same tap)
//   rx_data    : last correctly framed byte
//   rx_valid   : one-cycle strobe, rx_data valid in the same cycle
//   frame_err  : one-cycle strobe when the stop bit is sampled low
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 rx_s,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned BIT_W = $clog2(DATA_BITS) + 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  // Mid-bit sampling needs a few clocks per bit to be meaningful.
  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_rx_core: CLKS_PER_BIT must be at least 4");
  end

  logic                 sync1_q;
  logic                 sync2_q;
  rx_state_e            state_q,   state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic [DATA_BITS-1:0] data_q,    data_d;
  logic                 valid_q,   valid_d;
  logic                 ferr_q,    ferr_d;
  logic                 armed_q,   armed_d;

  // Synchroniser and receiver state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      armed_q   <= 1'b1;
    end else begin
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      armed_q   <= armed_d;
    end
  end

  // Next-state and strobe logic for the frame decoder.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    armed_d   = armed_q;

    // A high line re-arms start detection after a frame error.
    if (sync2_q) begin
      armed_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (armed_q && !sync2_q) begin
          state_d   = START;
          clk_cnt_d = '0;
        end
      end

      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          if (!sync2_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            // Line bounced back high before mid-start: treat as a glitch.
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = CNT_W'(clk_cnt_q + 1'b1);
        end
      end

      DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {sync2_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = BIT_W'(bit_cnt_q + 1'b1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = STOP;
          end
        end else begin
          clk_cnt_d = CNT_W'(clk_cnt_q + 1'b1);
        end
      end

      STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          state_d   = IDLE;
          if (sync2_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            // Disarm so a held-low line cannot generate a stream of frames.
            ferr_d  = 1'b1;
            armed_d = 1'b0;
          end
        end else begin
          clk_cnt_d = CNT_W'(clk_cnt_q + 1'b1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx_s      = sync2_q;
  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/uart_break_reset.sv
// Taps the host-to-board UART line, decodes 8N1 bytes for debug and turns a
// long UART break into an active-low board reset held for a fixed time after
// the line returns high.
//   clk, rst   : system clock, synchronous active-high reset
//   ftdi_rx    : asynchronous UART line from the host, idle high
//   board_rst  : active-low board reset (1 = run, 0 = reset)
//   rx_data    : last received byte
//   rx_valid   : one-cycle strobe, rx_data valid in the same cycle
//   frame_err  : one-cycle strobe on a low stop bit
//   break_det  : one-cycle strobe when a break is first recognised
module uart_break_reset
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 100000000,
  parameter int unsigned BAUD          = 115200,
  parameter int unsigned BREAK_BITS    = 20,
  parameter int unsigned RST_HOLD_CLKS = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ftdi_rx,
  output logic                 board_rst,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 break_det
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int unsigned BREAK_CLKS   = BREAK_BITS * CLKS_PER_BIT;
  localparam int unsigned LOW_W        = $clog2(BREAK_CLKS) + 1;
  localparam int unsigned HOLD_W       = $clog2(RST_HOLD_CLKS) + 1;

  localparam logic [LOW_W-1:0]  LOW_MAX   = LOW_W'(BREAK_CLKS);
  localparam logic [LOW_W-1:0]  LOW_LAST  = LOW_W'(BREAK_CLKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD_CLKS);

  logic              rx_s;
  logic [LOW_W-1:0]  low_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              board_rst_q;
  logic              break_det_q;
  logic              break_active;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx_core (
    .clk       (clk),
    .rst       (rst),
    .rx        (ftdi_rx),
    .rx_s      (rx_s),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  assign break_active = (low_cnt_q == LOW_MAX);

  // Break detector (saturating low-time counter) and reset stretcher.
  always_ff @(posedge clk) begin
    if (rst) begin
      low_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      board_rst_q <= 1'b1;
      break_det_q <= 1'b0;
    end else begin
      if (rx_s) begin
        low_cnt_q <= '0;
      end else if (!break_active) begin
        low_cnt_q <= LOW_W'(low_cnt_q + 1'b1);
      end

      // Strobe coincides with the counter reaching saturation.
      break_det_q <= !rx_s && (low_cnt_q == LOW_LAST);

      if (break_active) begin
        hold_cnt_q <= HOLD_LOAD;
      end else if (hold_cnt_q != '0) begin
        hold_cnt_q <= HOLD_W'(hold_cnt_q - 1'b1);
      end

      board_rst_q <= !(break_active || (hold_cnt_q != '0));
    end
  end

  assign board_rst = board_rst_q;
  assign break_det = break_det_q;

endmodule

// File: tb/tb_uart_break_reset.sv
// Self-checking bench for uart_break_reset at 16 clocks per bit, a 320-clock
// break threshold and a 50-clock reset hold.
module tb_uart_break_reset;

  localparam int unsigned CPB  = 16;
  localparam int unsigned BC   = 320;
  localparam int unsigned HOLD = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       ftdi_rx;
  logic       board_rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       break_det;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  uart_break_reset #(
    .CLK_FREQ_HZ   (1600),
    .BAUD          (100),
    .BREAK_BITS    (20),
    .RST_HOLD_CLKS (HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ftdi_rx   (ftdi_rx),
    .board_rst (board_rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .break_det (break_det)
  );

  // Reference for the break/reset path: the line seen two clocks late, the
  // length of the current low run, and how long ago a break was last active.
  int unsigned cyc = 0;
  logic        m_s1, m_rxs;
  int unsigned m_low, m_since, lrun_new;
  logic        exp_board, exp_break;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_s1      = 1'b1;
      m_rxs     = 1'b1;
      m_low     = 0;
      m_since   = HOLD + 1;
      exp_board = 1'b1;
      exp_break = 1'b0;
    end else begin
      lrun_new  = m_rxs ? 0 : ((m_low < BC) ? m_low + 1 : BC);
      exp_break = (lrun_new == BC) && (m_low != BC);
      // Board held in reset while the break is active and HOLD cycles after.
      exp_board = !(m_since <= HOLD);
      m_since   = (lrun_new == BC) ? 0 : ((m_since > HOLD) ? HOLD + 1 : m_since + 1);
      m_low     = lrun_new;
      m_rxs     = m_s1;
      m_s1      = ftdi_rx;
    end
  end

  // Observer: tallies strobes, captures bytes, counts cycle mismatches.
  int unsigned n_valid = 0, n_ferr = 0, n_brk = 0;
  int unsigned board_err = 0, brk_err = 0;
  int unsigned valid_cyc = 0, brk_cyc = 0;
  logic [7:0]  got_arr [0:63];

  always @(negedge clk) begin
    if (board_rst !== exp_board) board_err++;
    if (break_det !== exp_break) brk_err++;
    if (rx_valid === 1'b1) begin
      if (n_valid < 64) got_arr[n_valid] = rx_data;
      n_valid++;
      valid_cyc = cyc;
    end
    if (frame_err === 1'b1) n_ferr++;
    if (break_det === 1'b1) begin
      n_brk++;
      brk_cyc = cyc;
    end
  end

  logic [7:0] last_good = 8'h00;
  int unsigned v0, f0, b0, be0, ke0, t0;

  task automatic drive_line(input logic v, input int unsigned n);
    ftdi_rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic good_stop);
    drive_line(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_line(b[i], CPB);
    drive_line(good_stop, CPB);
  endtask

  task automatic snap();
    v0  = n_valid;
    f0  = n_ferr;
    b0  = n_brk;
    be0 = board_err;
    ke0 = brk_err;
  endtask

  task automatic check_trace(input string name);
    vectors++;
    if (board_err - be0 !== 0) begin
      miscompares++;
      $display("FAIL %s_board_rst_trace: %0d cycles differ, expected 0", name, board_err - be0);
    end
    vectors++;
    if (brk_err - ke0 !== 0) begin
      miscompares++;
      $display("FAIL %s_break_det_trace: %0d cycles differ, expected 0", name, brk_err - ke0);
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    ftdi_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (board_rst !== 1'b1) begin miscompares++; $display("FAIL reset_board_rst: got %b expected 1", board_rst); end
    vectors++;
    if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    vectors++;
    if ({rx_valid, frame_err, break_det} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b expected 000", {rx_valid, frame_err, break_det});
    end
    rst = 1'b0;
    drive_line(1'b1, 5);
  endtask

  task automatic test_single_byte();
    snap();
    t0 = cyc;
    send_byte(8'hA5, 1'b1);
    drive_line(1'b1, 20);
    last_good = 8'hA5;
    vectors++;
    if (n_valid - v0 !== 1) begin miscompares++; $display("FAIL single_valid_count: got %0d expected 1", n_valid - v0); end
    vectors++;
    if (got_arr[v0] !== 8'hA5) begin miscompares++; $display("FAIL single_data: got %h expected a5", got_arr[v0]); end
    vectors++;
    if (valid_cyc - t0 < 150 || valid_cyc - t0 > 158) begin
      miscompares++;
      $display("FAIL single_latency: got %0d expected 150..158", valid_cyc - t0);
    end
    vectors++;
    if (n_ferr - f0 !== 0 || n_brk - b0 !== 0) begin
      miscompares++;
      $display("FAIL single_no_errors: frame_err %0d break_det %0d expected 0 0", n_ferr - f0, n_brk - b0);
    end
    check_trace("single");
  endtask

  task automatic test_back_to_back();
    snap();
    send_byte(8'h55, 1'b1);
    send_byte(8'h0F, 1'b1);
    drive_line(1'b1, 20);
    last_good = 8'h0F;
    vectors++;
    if (n_valid - v0 !== 2) begin miscompares++; $display("FAIL b2b_valid_count: got %0d expected 2", n_valid - v0); end
    vectors++;
    if (got_arr[v0] !== 8'h55 || got_arr[v0+1] !== 8'h0F) begin
      miscompares++;
      $display("FAIL b2b_data: got %h %h expected 55 0f", got_arr[v0], got_arr[v0+1]);
    end
    vectors++;
    if (n_ferr - f0 !== 0) begin miscompares++; $display("FAIL b2b_frame_err: got %0d expected 0", n_ferr - f0); end
    check_trace("b2b");
  endtask

  task automatic test_frame_error();
    snap();
    send_byte(8'h00, 1'b0);
    drive_line(1'b1, 20);
    vectors++;
    if (n_ferr - f0 !== 1) begin miscompares++; $display("FAIL ferr_count: got %0d expected 1", n_ferr - f0); end
    vectors++;
    if (n_valid - v0 !== 0) begin miscompares++; $display("FAIL ferr_valid_count: got %0d expected 0", n_valid - v0); end
    vectors++;
    if (rx_data !== last_good) begin miscompares++; $display("FAIL ferr_rx_data_kept: got %h expected %h", rx_data, last_good); end
    vectors++;
    if (board_rst !== 1'b1) begin miscompares++; $display("FAIL ferr_board_rst: got %b expected 1", board_rst); end
    check_trace("ferr");
  endtask

  task automatic test_glitch();
    snap();
    drive_line(1'b0, 4);
    drive_line(1'b1, 30);
    vectors++;
    if (n_valid - v0 !== 0 || n_ferr - f0 !== 0 || n_brk - b0 !== 0) begin
      miscompares++;
      $display("FAIL glitch_strobes: valid %0d ferr %0d brk %0d expected 0 0 0", n_valid - v0, n_ferr - f0, n_brk - b0);
    end
    check_trace("glitch");
  endtask

  task automatic test_random();
    logic [7:0]  exp_q[$];
    logic [7:0]  b;
    logic        bad, prev_bad;
    int unsigned g, ferr_exp;
    snap();
    prev_bad = 1'b0;
    ferr_exp = 0;
    for (int i = 0; i < 10; i++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(3) == 0);
      g   = $urandom_range(12);
      if (prev_bad && g < 2) g = 2;
      if (g > 0) drive_line(1'b1, g);
      if ($urandom_range(3) == 0) begin
        drive_line(1'b0, $urandom_range(6, 1));
        drive_line(1'b1, 12);
      end
      send_byte(b, !bad);
      if (bad) ferr_exp++;
      else begin
        exp_q.push_back(b);
        last_good = b;
      end
      prev_bad = bad;
    end
    drive_line(1'b1, 20);
    vectors++;
    if (n_valid - v0 !== exp_q.size()) begin
      miscompares++;
      $display("FAIL rand_valid_count: got %0d expected %0d", n_valid - v0, exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < int'(n_valid - v0); j++) begin
      vectors++;
      if (got_arr[v0+j] !== exp_q[j]) begin
        miscompares++;
        $display("FAIL rand_data[%0d]: got %h expected %h", j, got_arr[v0+j], exp_q[j]);
      end
    end
    vectors++;
    if (n_ferr - f0 !== ferr_exp) begin miscompares++; $display("FAIL rand_frame_err: got %0d expected %0d", n_ferr - f0, ferr_exp); end
    vectors++;
    if (rx_data !== last_good) begin miscompares++; $display("FAIL rand_rx_data: got %h expected %h", rx_data, last_good); end
    check_trace("rand");
  endtask

  task automatic test_break();
    snap();
    t0 = cyc;
    drive_line(1'b0, 400);
    vectors++;
    if (board_rst !== 1'b0) begin miscompares++; $display("FAIL break_board_low: got %b expected 0", board_rst); end
    drive_line(1'b1, 40);
    vectors++;
    if (board_rst !== 1'b0) begin miscompares++; $display("FAIL break_hold: got %b expected 0", board_rst); end
    drive_line(1'b1, 40);
    vectors++;
    if (board_rst !== 1'b1) begin miscompares++; $display("FAIL break_release: got %b expected 1", board_rst); end
    vectors++;
    if (n_brk - b0 !== 1) begin miscompares++; $display("FAIL break_count: got %0d expected 1", n_brk - b0); end
    vectors++;
    if (brk_cyc - t0 < 320 || brk_cyc - t0 > 325) begin
      miscompares++;
      $display("FAIL break_latency: got %0d expected 320..325", brk_cyc - t0);
    end
    vectors++;
    if (n_ferr - f0 !== 1 || n_valid - v0 !== 0) begin
      miscompares++;
      $display("FAIL break_frames: ferr %0d valid %0d expected 1 0", n_ferr - f0, n_valid - v0);
    end
    check_trace("break");
  endtask

  task automatic test_rst_mid_break();
    drive_line(1'b0, 340);
    vectors++;
    if (board_rst !== 1'b0) begin miscompares++; $display("FAIL rstmid_pre_board: got %b expected 0", board_rst); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++;
    if (board_rst !== 1'b1) begin miscompares++; $display("FAIL rstmid_board_release: got %b expected 1", board_rst); end
    snap();
    drive_line(1'b0, 300);
    vectors++;
    if (n_brk - b0 !== 0) begin miscompares++; $display("FAIL rstmid_early_break: got %0d expected 0", n_brk - b0); end
    drive_line(1'b0, 40);
    vectors++;
    if (n_brk - b0 !== 1) begin miscompares++; $display("FAIL rstmid_new_break: got %0d expected 1", n_brk - b0); end
    drive_line(1'b1, 80);
    vectors++;
    if (board_rst !== 1'b1) begin miscompares++; $display("FAIL rstmid_final_board: got %b expected 1", board_rst); end
    vectors++;
    if (n_ferr - f0 !== 1 || n_valid - v0 !== 0) begin
      miscompares++;
      $display("FAIL rstmid_frames: ferr %0d valid %0d expected 1 0", n_ferr - f0, n_valid - v0);
    end
    check_trace("rstmid");
  endtask

  initial begin
    rst     = 1'b1;
    ftdi_rx = 1'b1;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_random();
    test_break();
    test_rst_mid_break();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
